div_issue_ctrl: RTL

//  Execute-stage sequencer sitting directly upstream of the ALU/M-extension block. It issues
//  DIV/DIVU/REM/REMU to the multi-cycle divider and holds the pipeline via stall while it runs.
//  It resolves divide-by-zero and signed overflow itself, without using the divider.
//  It captures the selected quotient or remainder and presents it for exactly one cycle

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/div_special_case.sv | 31 +++
 rtl/div_issue_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and funct3 encodings for the divide issue sequencer
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  function automatic logic f3_is_unsigned(input logic [2:0] f3);
    return f3[0];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/div_special_case.sv
// rtl/div_special_case.sv - resolves divide-by-zero and signed overflow without the divider
module div_special_case
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [2:0]            funct3,
  output logic                  is_special,
  output logic [DATA_WIDTH-1:0] special_result
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic div_by_zero;
  logic overflow;

  always_comb begin
    div_by_zero    = (op2 == '0);
    overflow       = ~f3_is_unsigned(funct3) & (op1 == MOST_NEG) & (op2 == '1);
    is_special     = div_by_zero | overflow;
    special_result = '0;
    if (div_by_zero) begin
      special_result = f3_is_rem(funct3) ? op1 : '1;
    end else if (overflow) begin
      special_result = f3_is_rem(funct3) ? '0 : MOST_NEG;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issues DIV/REM to a multi-cycle divider and stalls EX until the result is ready
module div_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_is_div,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  flush,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  output logic                  div_signed,
  input  logic                  div_ready,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  stall,
  output logic                  md_valid,
  output logic [DATA_WIDTH-1:0] md_result
);

  div_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] dividend_q, dividend_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  signed_q, signed_d;
  logic                  rem_sel_q, rem_sel_d;

  logic                  issue;
  logic                  is_special;
  logic [DATA_WIDTH-1:0] special_result;

  assign issue = ex_valid & ex_is_div & ~flush;

  div_special_case #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_special (
    .op1           (op1),
    .op2           (op2),
    .funct3        (funct3),
    .is_special    (is_special),
    .special_result(special_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush in START still launches the divider, so it must be drained like a flush in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = is_special ? DONE : START;
      START:   state_d = flush ? DRAIN : BUSY;
      BUSY: begin
        if (flush) begin
          state_d = DRAIN;
        end else if (div_ready) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      DRAIN:   if (div_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_start = 1'b0;
    stall     = 1'b0;
    md_valid  = 1'b0;
    case (state_q)
      IDLE:  stall = issue;
      START: begin
        div_start = 1'b1;
        stall     = 1'b1;
      end
      BUSY:  stall = 1'b1;
      DONE:  md_valid = ~flush;
      DRAIN: stall = ex_valid & ex_is_div;
      default: stall = 1'b0;
    endcase
  end

  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    signed_d   = signed_q;
    rem_sel_d  = rem_sel_q;
    if (state_q == IDLE && issue) begin
      if (is_special) begin
        result_d = special_result;
      end else begin
        dividend_d = op1;
        divisor_d  = op2;
        signed_d   = ~f3_is_unsigned(funct3);
        rem_sel_d  = f3_is_rem(funct3);
      end
    end else if (state_q == BUSY && div_ready && !flush) begin
      result_d = rem_sel_q ? div_remainder : div_quotient;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      signed_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
    end else begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      signed_q   <= signed_d;
      rem_sel_q  <= rem_sel_d;
    end
  end

  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign div_signed   = signed_q;
  assign md_result    = result_q;

endmodule
